mul8_acc: RTL and testbench



---
 rtl/mul8_pkg.sv | 24 ++
 rtl/mul8_acc_if.sv | 35 +++
 rtl/mul8.sv | 12 +
 rtl/mul8_acc.sv | 99 +++++++++
 tb/tb_mul8_acc.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mul8_pkg.sv
// Shared constants and helpers for the mul8 multiply / accumulate sandbox path.
// Default accumulator width is derived so a full group can never overflow.
package mul8_pkg;

   localparam int MUL_IN_W  = 8;
   localparam int MUL_OUT_W = 2 * MUL_IN_W;

   // Ceiling log2, usable in constant expressions (clog2(1) = 0).
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'(1) << result) < 64'(value)) begin
            result = result + 1;
         end
      end
      return result;
   endfunction

   localparam int DEF_N_TERMS = 4;
   localparam int DEF_CNT_W   = 8;
   localparam int DEF_ACC_W   = MUL_OUT_W + clog2(DEF_N_TERMS);

endpackage

// File: rtl/mul8_acc_if.sv
// Valid/ready bundle between a product source, the accumulator and its sum consumer.
// The slave side is the accumulator; the master side drives products and takes sums.
interface mul8_acc_if
   import mul8_pkg::*;
#(
   parameter int IN_W  = MUL_OUT_W,
   parameter int ACC_W = DEF_ACC_W
);

   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_data;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );

endinterface

// File: rtl/mul8.sv
// Combinational unsigned 8x8 multiplier feeding the accumulator path.
module mul8
   import mul8_pkg::*;
(
   input  logic [MUL_IN_W-1:0]  a,
   input  logic [MUL_IN_W-1:0]  b,
   output logic [MUL_OUT_W-1:0] p
);

   assign p = MUL_OUT_W'(a) * MUL_OUT_W'(b);

endmodule

// File: rtl/mul8_acc.sv
// Sums each group of N_TERMS products and hands the group sum to a one-entry
// registered output buffer; the closing term stalls only while that buffer is full.
module mul8_acc
   import mul8_pkg::*;
#(
   parameter int IN_W    = MUL_OUT_W,
   parameter int N_TERMS = DEF_N_TERMS,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int ACC_W   = DEF_ACC_W
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   mul8_acc_if.slave  bus,
   output logic       busy
);

   // Any illegal width combination stops elaboration, so the sum cannot wrap.
   if (N_TERMS < 2 || N_TERMS > 256) begin : g_bad_terms
      $error("mul8_acc: N_TERMS must be within 2..256");
   end
   if ((64'(1) << CNT_W) < 64'(N_TERMS)) begin : g_bad_cnt_w
      $error("mul8_acc: CNT_W too narrow for N_TERMS");
   end
   if (ACC_W < IN_W + clog2(N_TERMS)) begin : g_bad_acc_w
      $error("mul8_acc: ACC_W too narrow for a full group sum");
   end
   if ($bits(bus.in_data) != IN_W || $bits(bus.out_data) != ACC_W) begin : g_bad_if
      $error("mul8_acc: interface widths do not match module parameters");
   end

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [ACC_W-1:0] acc_q,       acc_d;
   logic [ACC_W-1:0] out_data_q,  out_data_d;
   logic             out_valid_q, out_valid_d;

   logic             last;
   logic             in_ready;
   logic             in_beat;
   logic             out_beat;
   logic [ACC_W-1:0] sum;

   assign last     = (cnt_q == LAST_CNT);
   // rst_n gates ready so nothing is offered as accepted while held in reset.
   assign in_ready = rst_n & ~clr & (~last | ~out_valid_q | bus.out_ready);
   assign in_beat  = bus.in_valid & in_ready;
   assign out_beat = out_valid_q & bus.out_ready;
   assign sum      = acc_q + ACC_W'(bus.in_data);

   always_comb begin
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;

      if (clr) begin
         cnt_d = '0;
         acc_d = '0;
      end else if (in_beat) begin
         if (last) begin
            cnt_d      = '0;
            acc_d      = '0;
            out_data_d = sum;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
            acc_d = sum;
         end
      end

      // A closing beat refills the buffer in the same cycle it drains.
      if (in_beat && last) begin
         out_valid_d = 1'b1;
      end else if (out_beat) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         acc_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign busy          = (cnt_q != '0);

endmodule

// File: tb/tb_mul8_acc.sv
// Directed bench for mul8_acc: handshake, backpressure, clear, async reset and a
// full sweep of mul8 products summed in groups of four.
module tb_mul8_acc;
   import mul8_pkg::*;

   localparam int IN_W    = MUL_OUT_W;
   localparam int N_TERMS = 4;
   localparam int ACC_W   = DEF_ACC_W;

   logic clk;
   logic rst_n;
   logic clr;
   logic busy;

   logic                 use_mul;
   logic [IN_W-1:0]      drv_data;
   logic [MUL_IN_W-1:0]  mul_a;
   logic [MUL_IN_W-1:0]  mul_b;
   logic [MUL_OUT_W-1:0] mul_p;

   int checks;
   int errors;

   mul8_acc_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus ();

   mul8 u_mul (
      .a (mul_a),
      .b (mul_b),
      .p (mul_p)
   );

   mul8_acc #(
      .IN_W    (IN_W),
      .N_TERMS (N_TERMS),
      .CNT_W   (8),
      .ACC_W   (ACC_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .bus   (bus),
      .busy  (busy)
   );

   assign bus.in_data = use_mul ? mul_p : drv_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks = checks + 1;
      if (actual !== expected) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Drive inputs just after a falling edge and let combinational paths settle.
   task automatic applyStimulus(input logic v, input logic [IN_W-1:0] d,
                                input logic r, input logic c);
      bus.in_valid  = v;
      drv_data      = d;
      bus.out_ready = r;
      clr           = c;
      #1;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic sendBeat(input string tag, input logic [IN_W-1:0] d, input logic r);
      applyStimulus(1'b1, d, r, 1'b0);
      checkOutput(tag, 32'(bus.in_ready), 32'd1);
      tick();
   endtask

   initial begin
      int group_sum;
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      clr           = 1'b0;
      use_mul       = 1'b0;
      drv_data      = '0;
      mul_a         = '0;
      mul_b         = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;

      // Test 1: reset values, then four beats of 255*255
      tick();
      tick();
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_out_data",  32'(bus.out_data),  32'd0);
      checkOutput("rst_busy",      32'(busy),          32'd0);
      checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("rel_in_ready",  32'(bus.in_ready),  32'd1);
      tick();
      use_mul = 1'b1;
      mul_a   = 8'd255;
      mul_b   = 8'd255;
      for (int i = 0; i < 4; i++) begin
         sendBeat("t1_in_ready", '0, 1'b1);
         if (i == 2) checkOutput("t1_busy_mid", 32'(busy), 32'd1);
      end
      use_mul = 1'b0;
      checkOutput("t1_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("t1_out_data",  32'(bus.out_data),  32'd260100);
      checkOutput("t1_busy",      32'(busy),          32'd0);

      // Test 2: back-to-back groups 1..4 and 5..8 with no bubbles
      for (int i = 1; i <= 8; i++) begin
         sendBeat("t2_in_ready", IN_W'(i), 1'b1);
         if (i == 4) begin
            checkOutput("t2_valid_g1", 32'(bus.out_valid), 32'd1);
            checkOutput("t2_data_g1",  32'(bus.out_data),  32'd10);
         end
         if (i == 5) checkOutput("t2_drained", 32'(bus.out_valid), 32'd0);
      end
      checkOutput("t2_valid_g2", 32'(bus.out_valid), 32'd1);
      checkOutput("t2_data_g2",  32'(bus.out_data),  32'd26);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      tick();
      checkOutput("t2_idle_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("t2_hold_data",  32'(bus.out_data),  32'd26);

      // Test 3: backpressure stalls only the closing term
      for (int i = 0; i < 7; i++) begin
         sendBeat("t3_in_ready", 16'd100, 1'b0);
      end
      checkOutput("t3_valid_held", 32'(bus.out_valid), 32'd1);
      checkOutput("t3_data_held",  32'(bus.out_data),  32'd400);
      applyStimulus(1'b1, 16'd100, 1'b0, 1'b0);
      checkOutput("t3_stall_ready", 32'(bus.in_ready), 32'd0);
      tick();
      checkOutput("t3_stall_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("t3_stall_busy",  32'(busy),          32'd1);
      applyStimulus(1'b1, 16'd100, 1'b1, 1'b0);
      checkOutput("t3_release_ready", 32'(bus.in_ready), 32'd1);
      tick();
      checkOutput("t3_g2_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("t3_g2_data",  32'(bus.out_data),  32'd400);
      checkOutput("t3_g2_busy",  32'(busy),          32'd0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      tick();
      checkOutput("t3_drained", 32'(bus.out_valid), 32'd0);

      // Test 4: clear discards the partial group and refuses the offered beat
      sendBeat("t4_in_ready", 16'd10, 1'b1);
      sendBeat("t4_in_ready", 16'd20, 1'b1);
      applyStimulus(1'b1, 16'd30, 1'b1, 1'b1);
      checkOutput("t4_clr_ready", 32'(bus.in_ready), 32'd0);
      tick();
      checkOutput("t4_clr_busy", 32'(busy), 32'd0);
      sendBeat("t4_in_ready", 16'd30, 1'b1);
      sendBeat("t4_in_ready", 16'd40, 1'b1);
      sendBeat("t4_in_ready", 16'd50, 1'b1);
      sendBeat("t4_in_ready", 16'd60, 1'b1);
      checkOutput("t4_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("t4_data",  32'(bus.out_data),  32'd180);

      // Test 5: asynchronous reset between edges in the middle of a group
      sendBeat("t5_in_ready", 16'd7, 1'b1);
      sendBeat("t5_in_ready", 16'd7, 1'b1);
      checkOutput("t5_busy_pre", 32'(busy), 32'd1);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("t5_rst_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("t5_rst_data",  32'(bus.out_data),  32'd0);
      checkOutput("t5_rst_busy",  32'(busy),          32'd0);
      checkOutput("t5_rst_ready", 32'(bus.in_ready),  32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("t5_no_pulse", 32'(bus.out_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         sendBeat("t5_in_ready", 16'd1, 1'b1);
      end
      checkOutput("t5_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("t5_data",  32'(bus.out_data),  32'd4);

      // Test 6: every a,b pair through mul8, summed in groups of four
      use_mul   = 1'b1;
      group_sum = 0;
      for (int i = 0; i < 65536; i++) begin
         mul_a = MUL_IN_W'(i >> 8);
         mul_b = MUL_IN_W'(i & 255);
         group_sum = group_sum + (i >> 8) * (i & 255);
         applyStimulus(1'b1, '0, 1'b1, 1'b0);
         tick();
         if ((i % 4) == 3) begin
            checkOutput("t6_sum", 32'(bus.out_data) | (32'(!bus.out_valid) << 31),
                        32'(group_sum));
            group_sum = 0;
         end
      end
      use_mul = 1'b0;
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
